// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with a valid/ready request port and a hardware clear sequencer.
// Optional macro RAM_OUT_REG_EN adds an output register stage, giving 2-cycle read latency.
module ram_sp_clr #(
    parameter int              DATA_W   = 8,
    parameter int              ADDR_W   = 4,
    parameter int              DEPTH    = 1 << ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err_oob,
    output logic              busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
    logic              clr_last;

    logic              accept;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              err_oob_reg;

    assign clr_last = (clr_ptr_reg == ADDR_W'(DEPTH - 1));
    assign in_range = (32'(req_addr) < DEPTH);
    assign accept   = req_valid && req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (clr_last) begin
                    state_next   = ST_READY;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr_reg + 1'b1;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    // Output logic; a clear request blocks acceptance in the same cycle
    always_comb begin
        busy      = (state_reg == ST_CLEAR);
        req_ready = (state_reg == ST_READY) && !clr;
    end

    // One write port shared by the clear sequencer and accepted in-range writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        if (state_reg == ST_CLEAR) begin
            mem_we    = rst;
            mem_waddr = clr_ptr_reg;
            mem_wdata = INIT_VAL;
        end else if (accept && req_we && in_range) begin
            mem_we    = rst;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read; out-of-range reads return zero and flag the error
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            err_oob_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= accept && !req_we;
            err_oob_reg  <= accept && !in_range;
            if (accept && !req_we) begin
                rd_data_reg <= in_range ? mem[req_addr] : '0;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_W-1:0] rd_data_out_reg;
    logic              rd_valid_out_reg;
    logic              err_oob_out_reg;

    // Output stage is cleared only by reset, so reads in flight survive a clear request
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_out_reg  <= '0;
            rd_valid_out_reg <= 1'b0;
            err_oob_out_reg  <= 1'b0;
        end else begin
            rd_data_out_reg  <= rd_data_reg;
            rd_valid_out_reg <= rd_valid_reg;
            err_oob_out_reg  <= err_oob_reg;
        end
    end

    assign rd_data  = rd_data_out_reg;
    assign rd_valid = rd_valid_out_reg;
    assign err_oob  = err_oob_out_reg;
`else
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign err_oob  = err_oob_reg;
`endif

endmodule
